// File: rtl/fifo_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_buffer_if
//  Brief    : Request/status bundle between the command producer and the
//             4-entry FIFO storage stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  FIFOBUFFER_Flush;
  logic                  FIFOBUFFER_ClrErr;
  logic                  FIFOBUFFER_WrEn;
  logic [DATA_WIDTH-1:0] FIFOBUFFER_WrData;
  logic                  FIFOBUFFER_RdEn;
  logic [DATA_WIDTH-1:0] FIFOBUFFER_RdData;
  logic                  FIFOBUFFER_RdValid;
  logic                  FIFOBUFFER_Full;
  logic                  FIFOBUFFER_Empty;
  logic [ADDR_WIDTH:0]   FIFOBUFFER_Count;
  logic [ADDR_WIDTH-1:0] FIFOBUFFER_WrPointer;
  logic [ADDR_WIDTH-1:0] FIFOBUFFER_RdPointer;
  logic                  FIFOBUFFER_Overflow;
  logic                  FIFOBUFFER_Underflow;

  // Producer/consumer side: issues requests, observes data and status
  modport master (
    output FIFOBUFFER_Flush, FIFOBUFFER_ClrErr,
    output FIFOBUFFER_WrEn, FIFOBUFFER_WrData, FIFOBUFFER_RdEn,
    input  FIFOBUFFER_RdData, FIFOBUFFER_RdValid,
    input  FIFOBUFFER_Full, FIFOBUFFER_Empty, FIFOBUFFER_Count,
    input  FIFOBUFFER_WrPointer, FIFOBUFFER_RdPointer,
    input  FIFOBUFFER_Overflow, FIFOBUFFER_Underflow
  );

  // FIFO side: accepts requests, drives data and status
  modport slave (
    input  FIFOBUFFER_Flush, FIFOBUFFER_ClrErr,
    input  FIFOBUFFER_WrEn, FIFOBUFFER_WrData, FIFOBUFFER_RdEn,
    output FIFOBUFFER_RdData, FIFOBUFFER_RdValid,
    output FIFOBUFFER_Full, FIFOBUFFER_Empty, FIFOBUFFER_Count,
    output FIFOBUFFER_WrPointer, FIFOBUFFER_RdPointer,
    output FIFOBUFFER_Overflow, FIFOBUFFER_Underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_buffer
//  Brief    : Synchronous FIFO with registered read data, registered
//             full/empty/count status and sticky overflow/underflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input wire logic     CLK,
  input wire logic     FIFOBUFFER_RST,
  fifo_buffer_if.slave bus
);
  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH   = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_full;
  logic                  r_empty;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_rej;
  logic                  w_rd_rej;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Flush masks every request in its cycle, so it neither moves data nor
  // raises an error flag. Blocking uses the registered Full/Empty, which is
  // why a freed slot is never reused (and fresh data never bypassed) in the
  // same cycle.
  assign w_wr_acc = bus.FIFOBUFFER_WrEn && !r_full  && !bus.FIFOBUFFER_Flush;
  assign w_rd_acc = bus.FIFOBUFFER_RdEn && !r_empty && !bus.FIFOBUFFER_Flush;
  assign w_wr_rej = bus.FIFOBUFFER_WrEn &&  r_full  && !bus.FIFOBUFFER_Flush;
  assign w_rd_rej = bus.FIFOBUFFER_RdEn &&  r_empty && !bus.FIFOBUFFER_Flush;

  // Next occupancy; Full/Empty are derived from it so they track Count exactly
  always_comb begin
    w_count_next = r_count;
    if (bus.FIFOBUFFER_Flush) begin
      w_count_next = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + C_CNT_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - C_CNT_ONE;
    end
  end

  // Storage array: written on accepted writes only, deliberately not reset
  always_ff @(posedge CLK) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.FIFOBUFFER_WrData;
    end
  end

  // Pointers, status, read data and sticky error flags
  always_ff @(posedge CLK or posedge FIFOBUFFER_RST) begin
    if (FIFOBUFFER_RST) begin
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_full     <= (w_count_next == C_DEPTH);
      r_empty    <= (w_count_next == '0);
      r_rd_valid <= w_rd_acc;

      if (bus.FIFOBUFFER_Flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        // Pointers wrap naturally at ADDR_WIDTH bits
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
        if (w_rd_acc) begin
          r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end

      // A new error in the same cycle as a clear takes priority
      if (w_wr_rej) begin
        r_overflow <= 1'b1;
      end else if (bus.FIFOBUFFER_ClrErr) begin
        r_overflow <= 1'b0;
      end
      if (w_rd_rej) begin
        r_underflow <= 1'b1;
      end else if (bus.FIFOBUFFER_ClrErr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.FIFOBUFFER_RdData    = r_rd_data;
  assign bus.FIFOBUFFER_RdValid   = r_rd_valid;
  assign bus.FIFOBUFFER_Full      = r_full;
  assign bus.FIFOBUFFER_Empty     = r_empty;
  assign bus.FIFOBUFFER_Count     = r_count;
  assign bus.FIFOBUFFER_WrPointer = r_wr_ptr;
  assign bus.FIFOBUFFER_RdPointer = r_rd_ptr;
  assign bus.FIFOBUFFER_Overflow  = r_overflow;
  assign bus.FIFOBUFFER_Underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_buffer
//  Brief    : Directed self-checking bench for fifo_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_buffer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fifo_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  fifo_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .CLK            (clk),
    .FIFOBUFFER_RST (rst),
    .bus            (bus)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.FIFOBUFFER_WrEn   = 1'b0;
    bus.FIFOBUFFER_RdEn   = 1'b0;
    bus.FIFOBUFFER_Flush  = 1'b0;
    bus.FIFOBUFFER_ClrErr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".rdata"}, 16'(bus.FIFOBUFFER_RdData), 16'h00);
    check({tag, ".rvalid"}, 16'(bus.FIFOBUFFER_RdValid), 16'd0);
    check({tag, ".full"}, 16'(bus.FIFOBUFFER_Full), 16'd0);
    check({tag, ".empty"}, 16'(bus.FIFOBUFFER_Empty), 16'd1);
    check({tag, ".count"}, 16'(bus.FIFOBUFFER_Count), 16'd0);
    check({tag, ".wptr"}, 16'(bus.FIFOBUFFER_WrPointer), 16'd0);
    check({tag, ".rptr"}, 16'(bus.FIFOBUFFER_RdPointer), 16'd0);
    check({tag, ".ovf"}, 16'(bus.FIFOBUFFER_Overflow), 16'd0);
    check({tag, ".udf"}, 16'(bus.FIFOBUFFER_Underflow), 16'd0);
  endtask

  task automatic write_word(input logic [7:0] d);
    bus.FIFOBUFFER_WrEn   = 1'b1;
    bus.FIFOBUFFER_WrData = d;
    tick();
    bus.FIFOBUFFER_WrEn   = 1'b0;
  endtask

  initial begin
    logic [7:0] fill [4];
    n_vec = 0;
    n_err = 0;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    rst = 1'b1;
    bus.FIFOBUFFER_WrData = 8'h00;
    idle();
    #1;
    check_reset("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Fill to full, then one rejected write
    for (int i = 0; i < 4; i++) begin
      write_word(fill[i]);
      check($sformatf("fill%0d.count", i), 16'(bus.FIFOBUFFER_Count), 16'(i + 1));
    end
    check("fill.full", 16'(bus.FIFOBUFFER_Full), 16'd1);
    check("fill.wptr_wrap", 16'(bus.FIFOBUFFER_WrPointer), 16'd0);
    write_word(8'h55);
    check("ovf.flag", 16'(bus.FIFOBUFFER_Overflow), 16'd1);
    check("ovf.count", 16'(bus.FIFOBUFFER_Count), 16'd4);

    // Drain in order, then one rejected read
    bus.FIFOBUFFER_RdEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain%0d.rdata", i), 16'(bus.FIFOBUFFER_RdData), 16'(fill[i]));
      check($sformatf("drain%0d.rvalid", i), 16'(bus.FIFOBUFFER_RdValid), 16'd1);
    end
    check("drain.empty", 16'(bus.FIFOBUFFER_Empty), 16'd1);
    tick();
    bus.FIFOBUFFER_RdEn = 1'b0;
    check("udf.flag", 16'(bus.FIFOBUFFER_Underflow), 16'd1);
    check("udf.rvalid", 16'(bus.FIFOBUFFER_RdValid), 16'd0);
    check("udf.rdata_hold", 16'(bus.FIFOBUFFER_RdData), 16'h44);
    check("udf.ovf_sticky", 16'(bus.FIFOBUFFER_Overflow), 16'd1);

    // Steady-state streaming at Count=2; pointers start at 0
    write_word(8'h01);
    write_word(8'h02);
    bus.FIFOBUFFER_WrEn = 1'b1;
    bus.FIFOBUFFER_RdEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.FIFOBUFFER_WrData = 8'(8'h10 + i);
      tick();
      check($sformatf("stream%0d.count", i), 16'(bus.FIFOBUFFER_Count), 16'd2);
      check($sformatf("stream%0d.rdata", i), 16'(bus.FIFOBUFFER_RdData),
            (i == 0) ? 16'h01 : (i == 1) ? 16'h02 : 16'(8'h10 + i - 2));
    end
    bus.FIFOBUFFER_WrEn = 1'b0;
    check("stream.rptr", 16'(bus.FIFOBUFFER_RdPointer), 16'd0);
    check("stream.wptr", 16'(bus.FIFOBUFFER_WrPointer), 16'd2);
    tick();
    check("stream.tail0", 16'(bus.FIFOBUFFER_RdData), 16'h16);
    tick();
    bus.FIFOBUFFER_RdEn = 1'b0;
    check("stream.tail1", 16'(bus.FIFOBUFFER_RdData), 16'h17);
    check("stream.empty", 16'(bus.FIFOBUFFER_Empty), 16'd1);

    // Clear flags, then simultaneous write+read while empty
    bus.FIFOBUFFER_ClrErr = 1'b1;
    tick();
    bus.FIFOBUFFER_ClrErr = 1'b0;
    check("clr.ovf", 16'(bus.FIFOBUFFER_Overflow), 16'd0);
    check("clr.udf", 16'(bus.FIFOBUFFER_Underflow), 16'd0);
    bus.FIFOBUFFER_WrEn   = 1'b1;
    bus.FIFOBUFFER_WrData = 8'hA5;
    bus.FIFOBUFFER_RdEn   = 1'b1;
    tick();
    bus.FIFOBUFFER_WrEn   = 1'b0;
    check("wr_rd_empty.udf", 16'(bus.FIFOBUFFER_Underflow), 16'd1);
    check("wr_rd_empty.count", 16'(bus.FIFOBUFFER_Count), 16'd1);
    check("wr_rd_empty.rvalid", 16'(bus.FIFOBUFFER_RdValid), 16'd0);
    tick();
    bus.FIFOBUFFER_RdEn = 1'b0;
    check("a5.rdata", 16'(bus.FIFOBUFFER_RdData), 16'hA5);
    check("a5.rvalid", 16'(bus.FIFOBUFFER_RdValid), 16'd1);
    check("a5.count", 16'(bus.FIFOBUFFER_Count), 16'd0);

    // Clear coinciding with a new underflow: the set wins
    bus.FIFOBUFFER_RdEn   = 1'b1;
    bus.FIFOBUFFER_ClrErr = 1'b1;
    tick();
    idle();
    check("clr_vs_set.udf", 16'(bus.FIFOBUFFER_Underflow), 16'd1);

    // Flush at Count=3 with both requests present
    write_word(8'h61);
    write_word(8'h62);
    write_word(8'h63);
    check("preflush.count", 16'(bus.FIFOBUFFER_Count), 16'd3);
    bus.FIFOBUFFER_Flush  = 1'b1;
    bus.FIFOBUFFER_WrEn   = 1'b1;
    bus.FIFOBUFFER_WrData = 8'h77;
    bus.FIFOBUFFER_RdEn   = 1'b1;
    tick();
    idle();
    check("flush.count", 16'(bus.FIFOBUFFER_Count), 16'd0);
    check("flush.empty", 16'(bus.FIFOBUFFER_Empty), 16'd1);
    check("flush.full", 16'(bus.FIFOBUFFER_Full), 16'd0);
    check("flush.wptr", 16'(bus.FIFOBUFFER_WrPointer), 16'd0);
    check("flush.rptr", 16'(bus.FIFOBUFFER_RdPointer), 16'd0);
    check("flush.rvalid", 16'(bus.FIFOBUFFER_RdValid), 16'd0);
    check("flush.rdata", 16'(bus.FIFOBUFFER_RdData), 16'hA5);
    check("flush.ovf", 16'(bus.FIFOBUFFER_Overflow), 16'd0);
    check("flush.udf", 16'(bus.FIFOBUFFER_Underflow), 16'd1);
    bus.FIFOBUFFER_ClrErr = 1'b1;
    tick();
    bus.FIFOBUFFER_ClrErr = 1'b0;
    check("postflush_clr.udf", 16'(bus.FIFOBUFFER_Underflow), 16'd0);

    // Asynchronous reset between edges with Count=3
    write_word(8'h81);
    write_word(8'h82);
    bus.FIFOBUFFER_RdEn = 1'b0;
    write_word(8'h83);
    check("prerst.count", 16'(bus.FIFOBUFFER_Count), 16'd3);
    // Leave a read outstanding so a stale RdData/RdValid would be visible
    bus.FIFOBUFFER_RdEn = 1'b1;
    tick();
    bus.FIFOBUFFER_RdEn = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    tick();
    check_reset("held_rst");
    rst = 1'b0;
    tick();
    check("after_rst.rvalid", 16'(bus.FIFOBUFFER_RdValid), 16'd0);
    check("after_rst.count", 16'(bus.FIFOBUFFER_Count), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
